adder: RTL and testbench

Parameterised synchronous up-counter ("adder") that accumulates increment requests into a registered WIDTH-bit value. It can be cleared at any time through a dedicated control input. It is a small utility block for event counting and accumulation inside clocked datapaths. All state lives in one register, updated on the rising edge of the single clock.

---
 rtl/adder.sv | 44 ++++
 tb/tb_adder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Synchronous up-counter with configurable step and wrap/saturate overflow.
// The count register drives out directly; there is no input-to-output path.
module adder #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned STEP     = 1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;

    // The extra top bit of the sum is the carry out of the counter.
    assign w_sum = {1'b0, r_count} + STEP_W;

    generate
        if (SATURATE) begin : g_sat
            assign w_next = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        end else begin : g_wrap
            assign w_next = w_sum[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= w_next;
        end
    end

    assign out = r_count;

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: reset, increment, clear priority,
// modulo wrap with steps 1 and 3, saturation with steps 1 and 4.
module tb_adder;

    logic       clk;
    logic       arstn;
    logic       clr_d, inc_d;
    logic       clr_s3, inc_s3;
    logic       clr_sat, inc_sat;
    logic       clr_s4, inc_s4;
    logic [7:0] out_d, out_s3, out_sat, out_s4;

    int checks;
    int errors;

    adder #(.WIDTH(8), .STEP(1), .SATURATE(1'b0)) u_d (
        .aclk(clk), .arstn(arstn), .clr(clr_d), .inc(inc_d), .out(out_d)
    );
    adder #(.WIDTH(8), .STEP(3), .SATURATE(1'b0)) u_s3 (
        .aclk(clk), .arstn(arstn), .clr(clr_s3), .inc(inc_s3), .out(out_s3)
    );
    adder #(.WIDTH(8), .STEP(1), .SATURATE(1'b1)) u_sat (
        .aclk(clk), .arstn(arstn), .clr(clr_sat), .inc(inc_sat), .out(out_sat)
    );
    adder #(.WIDTH(8), .STEP(4), .SATURATE(1'b1)) u_s4 (
        .aclk(clk), .arstn(arstn), .clr(clr_s4), .inc(inc_s4), .out(out_s4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; return 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        arstn   = 1'b0;
        clr_d   = 1'b0; inc_d   = 1'b0;
        clr_s3  = 1'bx; inc_s3  = 1'bx;
        clr_sat = 1'b0; inc_sat = 1'b0;
        clr_s4  = 1'b0; inc_s4  = 1'b0;

        // Reset held for 25 edges; X controls must not matter.
        for (int i = 0; i < 25; i++) step();
        chk("reset_d", out_d, 8'd0);
        chk("reset_s3_x", out_s3, 8'd0);
        checks++;
        assert (out_d !== 8'd1) else begin
            errors++;
            $error("FAIL reset_not1 observed=%0d expected=not 1", out_d);
        end
        arstn = 1'b1;
        clr_s3 = 1'b0; inc_s3 = 1'b0;
        step();
        step();
        chk("idle_after_release", out_d, 8'd0);

        // Increment: no combinational path, one-cycle latency.
        inc_d = 1'b1;
        #2;
        chk("no_comb_path", out_d, 8'd0);
        step(); chk("inc_1", out_d, 8'd1);
        step(); chk("inc_2", out_d, 8'd2);
        step(); chk("inc_3", out_d, 8'd3);
        inc_d = 1'b0;
        step(); chk("hold_3a", out_d, 8'd3);
        step(); chk("hold_3b", out_d, 8'd3);

        // Clear beats increment.
        inc_d = 1'b1;
        step();
        step(); chk("reach_5", out_d, 8'd5);
        clr_d = 1'b1;
        step(); chk("clr_wins", out_d, 8'd0);
        clr_d = 1'b0;
        step(); chk("after_clr", out_d, 8'd1);

        // Modulo wrap, step 1: 1 + 254 = 255, then 0.
        for (int i = 0; i < 254; i++) step();
        chk("reach_255", out_d, 8'd255);
        step(); chk("wrap_255_0", out_d, 8'd0);
        step(); chk("wrap_then_1", out_d, 8'd1);
        inc_d = 1'b0;

        // Modulo wrap, step 3: 86*3=258 -> 2; 170*3=510 -> 254; then 1.
        inc_s3 = 1'b1;
        for (int i = 0; i < 86; i++) step();
        chk("s3_wrap_2", out_s3, 8'd2);
        for (int i = 0; i < 84; i++) step();
        chk("s3_reach_254", out_s3, 8'd254);
        step(); chk("s3_254_to_1", out_s3, 8'd1);
        inc_s3 = 1'b0;
        step(); chk("s3_hold_1", out_s3, 8'd1);

        // Saturation, step 1.
        inc_sat = 1'b1;
        for (int i = 0; i < 254; i++) step();
        chk("sat_reach_254", out_sat, 8'd254);
        step(); chk("sat_255a", out_sat, 8'd255);
        step(); chk("sat_255b", out_sat, 8'd255);
        step(); chk("sat_255c", out_sat, 8'd255);
        inc_sat = 1'b0;
        clr_sat = 1'b1;
        step(); chk("sat_clr", out_sat, 8'd0);
        clr_sat = 1'b0;

        // Saturation, step 4: 252 + 4 clamps to 255.
        inc_s4 = 1'b1;
        for (int i = 0; i < 63; i++) step();
        chk("s4_reach_252", out_s4, 8'd252);
        step(); chk("s4_clamp", out_s4, 8'd255);
        step(); chk("s4_stay", out_s4, 8'd255);
        inc_s4 = 1'b0;

        // Reset mid-count wins over inc; counting resumes from 1.
        clr_d = 1'b1;
        step();
        clr_d = 1'b0;
        inc_d = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("reach_10", out_d, 8'd10);
        arstn = 1'b0;
        step(); chk("mid_reset", out_d, 8'd0);
        chk("mid_reset_s4", out_s4, 8'd0);
        arstn = 1'b1;
        step(); chk("resume_1", out_d, 8'd1);
        step(); chk("resume_2", out_d, 8'd2);
        inc_d = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
